pmod_dac_spi_responder: RTL and testbench

//   SPI Mode 0 responder that models the receiving end of the PMOD DAC link. It captures
//   CS_N/SCLK/DIN/LDAC_N frames and emulates the DAC register pipeline: shift register ->

---
 rtl/pmod_dac_spi_responder.sv | 156 +++++++++++++++
 tb/tb_pmod_dac_spi_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pmod_dac_spi_responder.sv
// SPI Mode 0 responder emulating the PMOD DAC register pipeline:
// shift register -> input register -> DAC register, with frame/error bookkeeping.
module pmod_dac_spi_responder #(
    parameter int RESOLUTION  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_cs_n,
    input  logic                  spi_sclk,
    input  logic                  spi_din,
    input  logic                  spi_ldac_n,
    output logic [RESOLUTION-1:0] input_reg,
    output logic [RESOLUTION-1:0] dac_value,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic                  dac_update,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam int BW = $clog2(RESOLUTION + 2);
    localparam logic [BW-1:0] BIT_FULL = BW'(RESOLUTION);
    localparam logic [BW-1:0] BIT_MAX  = BW'(RESOLUTION + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state;

    // Index SYNC_STAGES-1 is the synchronized level, index SYNC_STAGES the edge history.
    logic [SYNC_STAGES:0]   cs_pipe;
    logic [SYNC_STAGES:0]   sclk_pipe;
    logic [SYNC_STAGES:0]   ldac_pipe;
    logic [SYNC_STAGES-1:0] din_pipe;
    logic [SYNC_STAGES:0]   valid_pipe;

    logic [RESOLUTION-1:0]  sr;
    logic [BW-1:0]          bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_pipe    <= '1;
            sclk_pipe  <= '0;
            ldac_pipe  <= '1;
            din_pipe   <= '0;
            valid_pipe <= '0;
        end else begin
            cs_pipe    <= {cs_pipe[SYNC_STAGES-1:0], spi_cs_n};
            sclk_pipe  <= {sclk_pipe[SYNC_STAGES-1:0], spi_sclk};
            ldac_pipe  <= {ldac_pipe[SYNC_STAGES-1:0], spi_ldac_n};
            din_pipe   <= {din_pipe[SYNC_STAGES-1:0], spi_din};
            valid_pipe <= {valid_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges count only once the history flop holds a real pin sample, so a pin already
    // low at reset release (e.g. cs_n) must first be seen high before it can fall.
    logic hist_ok;
    logic cs_s, cs_h, sclk_s, sclk_h, ldac_s, ldac_h, din_s;
    logic cs_fall, cs_rise, sclk_rise, ldac_fall;

    assign hist_ok   = valid_pipe[SYNC_STAGES];
    assign cs_s      = cs_pipe[SYNC_STAGES-1];
    assign cs_h      = cs_pipe[SYNC_STAGES];
    assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
    assign sclk_h    = sclk_pipe[SYNC_STAGES];
    assign ldac_s    = ldac_pipe[SYNC_STAGES-1];
    assign ldac_h    = ldac_pipe[SYNC_STAGES];
    assign din_s     = din_pipe[SYNC_STAGES-1];

    assign cs_fall   = hist_ok &  cs_h   & ~cs_s;
    assign cs_rise   = hist_ok & ~cs_h   &  cs_s;
    assign sclk_rise = hist_ok & ~sclk_h &  sclk_s;
    assign ldac_fall = hist_ok &  ldac_h & ~ldac_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sr          <= '0;
            bit_cnt     <= '0;
            input_reg   <= '0;
            dac_value   <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            dac_update  <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            dac_update  <= 1'b0;

            if (state != COMMIT && ldac_fall) begin
                dac_value  <= input_reg;
                dac_update <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        state   <= SHIFT;
                        busy    <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (sclk_rise) begin
                        sr <= {sr[RESOLUTION-2:0], din_s};
                        if (bit_cnt != BIT_MAX)
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (cs_rise) begin
                        state <= COMMIT;
                        busy  <= 1'b0;
                    end
                end

                COMMIT: begin
                    state <= IDLE;
                    if (bit_cnt >= BIT_FULL) begin
                        input_reg   <= sr;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 1'b1;
                        if (!ldac_s) begin
                            dac_value  <= sr;
                            dac_update <= 1'b1;
                        end
                    end else begin
                        frame_error <= 1'b1;
                        if (err_count != '1)
                            err_count <= err_count + 1'b1;
                        // A discarded frame leaves nothing to load transparently.
                        if (ldac_fall) begin
                            dac_value  <= input_reg;
                            dac_update <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmod_dac_spi_responder.sv
// Directed bench for pmod_dac_spi_responder: drives SPI frames with SCLK at clk/8
// and checks registers, counters and pulse counts against hand-computed values.
module tb_pmod_dac_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_cs_n, spi_sclk, spi_din, spi_ldac_n;
    logic [15:0] input_reg, dac_value;
    logic        frame_done, frame_error, dac_update, busy;
    logic [7:0]  frame_count, err_count;

    int checks = 0;
    int errors = 0;
    int n_done = 0, n_err = 0, n_upd = 0;
    int base_done, base_err, base_upd;
    logic [15:0] word;

    always #5 clk = ~clk;

    pmod_dac_spi_responder dut (
        .clk         (clk),
        .rst         (rst),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_din     (spi_din),
        .spi_ldac_n  (spi_ldac_n),
        .input_reg   (input_reg),
        .dac_value   (dac_value),
        .frame_done  (frame_done),
        .frame_error (frame_error),
        .dac_update  (dac_update),
        .busy        (busy),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    // Pulse tallies let the directed steps check exact pulse counts per event.
    always @(posedge clk) begin
        if (frame_done)  n_done <= n_done + 1;
        if (frame_error) n_err  <= n_err + 1;
        if (dac_update)  n_upd  <= n_upd + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] bits, input int nbits, input bit close);
        @(negedge clk) spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_din = bits[i];
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        if (close) begin
            spi_cs_n = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic snapshot();
        base_done = n_done;
        base_err  = n_err;
        base_upd  = n_upd;
    endtask

    initial begin
        rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_din = 1'b0; spi_ldac_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rst_input_reg", 32'(input_reg), 32'h0);
        checkOutput("rst_dac_value", 32'(dac_value), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_frame_count", 32'(frame_count), 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("post_rst_no_pulses", 32'(n_done + n_err + n_upd), 32'h0);

        // 1: plain frame with LDAC high, then a separate LDAC pulse
        snapshot();
        applyStimulus(32'hA5C3, 16, 1'b1);
        checkOutput("t1_input_reg", 32'(input_reg), 32'hA5C3);
        checkOutput("t1_done_pulses", 32'(n_done - base_done), 32'd1);
        checkOutput("t1_dac_before_ldac", 32'(dac_value), 32'h0);
        checkOutput("t1_upd_before_ldac", 32'(n_upd - base_upd), 32'd0);
        spi_ldac_n = 1'b0; repeat (6) @(negedge clk);
        spi_ldac_n = 1'b1; repeat (6) @(negedge clk);
        checkOutput("t1_dac_after_ldac", 32'(dac_value), 32'hA5C3);
        checkOutput("t1_upd_after_ldac", 32'(n_upd - base_upd), 32'd1);
        checkOutput("t1_frame_count", 32'(frame_count), 32'd1);

        // 2: 17 clocks keep the last 16 bits
        applyStimulus(32'h18001, 17, 1'b1);
        checkOutput("t2_input_reg", 32'(input_reg), 32'h8001);
        checkOutput("t2_frame_count", 32'(frame_count), 32'd2);
        checkOutput("t2_err_count", 32'(err_count), 32'd0);

        // 3: short frame is discarded
        snapshot();
        applyStimulus(32'h1FF, 9, 1'b1);
        checkOutput("t3_err_pulses", 32'(n_err - base_err), 32'd1);
        checkOutput("t3_err_count", 32'(err_count), 32'd1);
        checkOutput("t3_input_reg", 32'(input_reg), 32'h8001);
        checkOutput("t3_dac_value", 32'(dac_value), 32'hA5C3);
        checkOutput("t3_frame_count", 32'(frame_count), 32'd2);

        // 4: LDAC held low across the frame close -> transparent load
        snapshot();
        spi_ldac_n = 1'b0; repeat (8) @(negedge clk);
        checkOutput("t4_dac_early_load", 32'(dac_value), 32'h8001);
        checkOutput("t4_upd_early", 32'(n_upd - base_upd), 32'd1);
        snapshot();
        applyStimulus(32'h1234, 16, 1'b1);
        checkOutput("t4_dac_value", 32'(dac_value), 32'h1234);
        checkOutput("t4_upd_single", 32'(n_upd - base_upd), 32'd1);
        checkOutput("t4_frame_count", 32'(frame_count), 32'd3);
        spi_ldac_n = 1'b1; repeat (8) @(negedge clk);

        // 5: reset mid-frame, CS still low at release must not start a frame
        applyStimulus(32'hFF, 8, 1'b0);
        checkOutput("t5_busy_mid", 32'(busy), 32'd1);
        snapshot();
        rst = 1'b1; repeat (3) @(negedge clk);
        checkOutput("t5_input_reg", 32'(input_reg), 32'h0);
        checkOutput("t5_dac_value", 32'(dac_value), 32'h0);
        checkOutput("t5_frame_count", 32'(frame_count), 32'h0);
        checkOutput("t5_err_count", 32'(err_count), 32'h0);
        checkOutput("t5_busy", 32'(busy), 32'h0);
        rst = 1'b0; repeat (20) @(negedge clk);
        checkOutput("t5_no_start_cs_low", 32'(busy), 32'h0);
        checkOutput("t5_no_pulses", 32'((n_done - base_done) + (n_err - base_err) + (n_upd - base_upd)), 32'h0);
        spi_cs_n = 1'b1; repeat (8) @(negedge clk);
        applyStimulus(32'h0F0F, 16, 1'b1);
        checkOutput("t5_next_input_reg", 32'(input_reg), 32'h0F0F);
        checkOutput("t5_next_frame_count", 32'(frame_count), 32'd1);
        checkOutput("t5_next_err_count", 32'(err_count), 32'd0);

        // 6: 255 more frames bring the count to 256, which wraps to 0
        for (int i = 0; i < 255; i++)
            applyStimulus({16'h0, 8'hC0, 8'(i)}, 16, 1'b1);
        checkOutput("t6_frame_count_wrap", 32'(frame_count), 32'd0);
        checkOutput("t6_input_reg_last", 32'(input_reg), 32'hC0FE);

        // SCLK and CS rise together on the 16th bit
        snapshot();
        word = 16'h3C5A;
        @(negedge clk) spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 15; i >= 1; i--) begin
            spi_din = word[i];
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        spi_din = word[0];
        repeat (4) @(negedge clk);
        spi_sclk = 1'b1;
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        spi_sclk = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t6_same_cycle_input_reg", 32'(input_reg), 32'h3C5A);
        checkOutput("t6_same_cycle_done", 32'(n_done - base_done), 32'd1);
        checkOutput("t6_same_cycle_err", 32'(n_err - base_err), 32'd0);
        checkOutput("t6_frame_count_after", 32'(frame_count), 32'd1);

        // Error counter saturates at all-ones after 256 empty frames
        snapshot();
        for (int i = 0; i < 256; i++)
            applyStimulus(32'h0, 0, 1'b1);
        checkOutput("t7_err_pulses", 32'(n_err - base_err), 32'd256);
        checkOutput("t7_err_count_sat", 32'(err_count), 32'd255);
        checkOutput("t7_input_reg_kept", 32'(input_reg), 32'h3C5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
